// File: rtl/fft_input_framer.sv
// fft_input_framer: frames a free-running ADC I/Q stream into NFFT-sample FFT frames
// through a small first-word-fall-through skid FIFO, and issues the FFT config word.
`default_nettype none

module fft_input_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_NFFT  = 13,
  parameter int FIFO_LOG2  = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] adc_tdata,
  input  logic                  adc_tvalid,
  input  logic                  frame_trigger,
  input  logic                  fwd_inv,
  input  logic                  cfg_update,
  output logic [23:0]           m_axis_config_tdata,
  output logic                  m_axis_config_tvalid,
  input  logic                  m_axis_config_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  output logic                  busy,
  output logic                  overflow,
  output logic [15:0]           frame_count
);

  localparam int NFFT  = 1 << LOG2_NFFT;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [LOG2_NFFT:0]   IN_LAST    = (LOG2_NFFT+1)'(NFFT - 1);
  localparam logic [LOG2_NFFT-1:0] OUT_LAST   = LOG2_NFFT'(NFFT - 1);
  localparam logic [FIFO_LOG2:0]   FULL_LEVEL = (FIFO_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    CONFIG  = 2'd0,
    IDLE    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [FIFO_LOG2-1:0]   wr_ptr;
  logic [FIFO_LOG2-1:0]   rd_ptr;
  logic [FIFO_LOG2:0]     level;
  logic [LOG2_NFFT:0]     in_count;
  logic [LOG2_NFFT-1:0]   out_count;
  logic                   fwd_inv_latched;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // A full FIFO still accepts a sample in a cycle where it is also being popped.
  assign full   = (level == FULL_LEVEL);
  assign pop    = m_axis_data_tvalid & m_axis_data_tready;
  assign push   = (state == CAPTURE) & adc_tvalid & (~full | pop);
  assign drop   = (state == CAPTURE) & adc_tvalid & full & ~pop;

  assign m_axis_data_tvalid  = (level != '0);
  assign m_axis_data_tdata   = m_axis_data_tvalid ? mem[rd_ptr] : '0;
  assign m_axis_data_tlast   = m_axis_data_tvalid & (out_count == OUT_LAST);
  assign m_axis_config_tdata = m_axis_config_tvalid ?
                               {7'b0, fwd_inv_latched, 11'b0, 5'(LOG2_NFFT)} : 24'h0;
  assign busy = (state != IDLE);

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= adc_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                <= CONFIG;
      m_axis_config_tvalid <= 1'b0;
      fwd_inv_latched      <= 1'b1;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      level                <= '0;
      in_count             <= '0;
      out_count            <= '0;
      frame_count          <= 16'd0;
      overflow             <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        in_count <= in_count + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_count <= out_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
      if (pop && m_axis_data_tlast) frame_count <= frame_count + 16'd1;

      case (state)
        CONFIG: begin
          // Coming out of reset the beat is not yet raised; raise it and sample fwd_inv.
          if (!m_axis_config_tvalid) begin
            m_axis_config_tvalid <= 1'b1;
            fwd_inv_latched      <= fwd_inv;
          end else if (m_axis_config_tready) begin
            m_axis_config_tvalid <= 1'b0;
            state                <= IDLE;
          end
        end
        IDLE: begin
          if (frame_trigger) begin
            state    <= CAPTURE;
            in_count <= '0;
            overflow <= 1'b0;
          end else if (cfg_update) begin
            state                <= CONFIG;
            m_axis_config_tvalid <= 1'b1;
            fwd_inv_latched      <= fwd_inv;
          end
        end
        CAPTURE: begin
          if (push && (in_count == IN_LAST)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_axis_data_tlast) state <= IDLE;
        end
        default: state <= CONFIG;
      endcase
    end
  end

endmodule

`default_nettype wire
